// File: rtl/nor_serial_ctrl.sv
// Bit-serial NOR operator: captures A/B on start, emits ~(A|B) BitsPerCycle bits per clock,
// then holds the registered result with valid_o until ack_i.
module nor_serial_ctrl #(
    parameter int unsigned Width        = 16,
    parameter int unsigned BitsPerCycle = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [Width-1:0] resultado_o,
    output logic             zero_o
);

    localparam int unsigned N    = Width / BitsPerCycle;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);
    localparam logic [Width-1:0] LowMask = {Width{1'b1}} >> (Width - BitsPerCycle);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Width-1:0]  a_q, a_d, b_q, b_d;
    logic [Width-1:0]  part_q, part_d;
    logic [Width-1:0]  res_q, res_d;
    logic              zero_q, zero_d;
    logic [Width-1:0]  nor_bits;

    // Only the low BitsPerCycle lanes are meaningful; they land at the MSB end of the partial.
    assign nor_bits = ~(a_q | b_q) & LowMask;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        res_d   = res_q;
        zero_d  = zero_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                part_d = (part_q >> BitsPerCycle) | (nor_bits << (Width - BitsPerCycle));
                a_d    = a_q >> BitsPerCycle;
                b_d    = b_q >> BitsPerCycle;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    res_d   = part_d;
                    zero_d  = (part_d == '0);
                    state_d = StDone;
                end
            end
            StDone: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_o      = (state_q != StIdle);
    assign valid_o     = (state_q == StDone);
    assign resultado_o = res_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_nor_serial_ctrl.sv
// Directed bench for nor_serial_ctrl (Width=16, BitsPerCycle=1).
module tb_nor_serial_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        ack;
    logic        busy;
    logic        valid;
    logic [15:0] res;
    logic        zero;

    int n_cmp;
    int n_bad;
    int lat;

    nor_serial_ctrl #(
        .Width        (16),
        .BitsPerCycle (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .a_i         (a),
        .b_i         (b),
        .ack_i       (ack),
        .busy_o      (busy),
        .valid_o     (valid),
        .resultado_o (res),
        .zero_o      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edges after the accepting edge until valid rises (bounded).
    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid && edges < 40) begin
            step();
            edges++;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        a     = '0;
        b     = '0;
        #12;
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_res", 32'(res), 32'h0);
        check("rst_zero", 32'(zero), 32'h0);
        rst_n = 1'b1;
        step();

        // 1: 0000/0000 -> FFFF, 16-edge latency
        a = 16'h0000; b = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        check("s1_busy", 32'(busy), 32'h1);
        wait_valid(lat);
        check("s1_lat", 32'(lat), 32'd16);
        check("s1_res", 32'(res), 32'hFFFF);
        check("s1_zero", 32'(zero), 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        check("s1_ack_valid", 32'(valid), 32'h0);
        check("s1_ack_busy", 32'(busy), 32'h0);
        check("s1_idle_hold", 32'(res), 32'hFFFF);

        // 2: FFFF/0000 -> 0000, zero
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        check("s2_lat", 32'(lat), 32'd16);
        check("s2_res", 32'(res), 32'h0000);
        check("s2_zero", 32'(zero), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 3: A5A5/0F0F -> 5050
        a = 16'hA5A5; b = 16'h0F0F; start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        check("s3_lat", 32'(lat), 32'd16);
        check("s3_res", 32'(res), 32'h5050);
        check("s3_zero", 32'(zero), 32'h0);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 4: second START during SHIFT is ignored
        a = 16'h00FF; b = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("s4_res_hold_shift", 32'(res), 32'h5050);
        a = 16'h1234; start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        check("s4_lat", 32'(lat + 3), 32'd16);
        check("s4_res", 32'(res), 32'hFF00);
        check("s4_zero", 32'(zero), 32'h0);

        // 5: hold in DONE, then ACK+START together, then START alone
        for (int i = 0; i < 10; i++) begin
            step();
            check("s5_valid_hold", 32'(valid), 32'h1);
            check("s5_res_hold", 32'(res), 32'hFF00);
        end
        a = 16'h0000; b = 16'hFFFF; ack = 1'b1; start = 1'b1;
        step();
        ack = 1'b0; start = 1'b0;
        check("s5_ackstart_valid", 32'(valid), 32'h0);
        check("s5_ackstart_busy", 32'(busy), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("s5_accept_busy", 32'(busy), 32'h1);
        wait_valid(lat);
        check("s5_lat", 32'(lat), 32'd16);
        check("s5_res", 32'(res), 32'h0000);
        check("s5_zero", 32'(zero), 32'h1);
        ack = 1'b1;
        step();
        ack = 1'b0;

        // 6: reset mid-SHIFT discards the op
        a = 16'h1234; b = 16'h0000; start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check("s6_rst_busy", 32'(busy), 32'h0);
        check("s6_rst_valid", 32'(valid), 32'h0);
        check("s6_rst_res", 32'(res), 32'h0);
        check("s6_rst_zero", 32'(zero), 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        step();
        check("s6_idle_busy", 32'(busy), 32'h0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid(lat);
        check("s6_lat", 32'(lat), 32'd16);
        check("s6_res", 32'(res), 32'hEDCB);
        check("s6_zero", 32'(zero), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
